// File: rtl/tff_toggle_sched.sv
// tff_toggle_sched
// Drives the T input of a downstream toggle flop with registered one-cycle
// enable pulses, one every half_period clocks. Runs either for a fixed
// number of toggles, ending with a one-cycle done pulse, or continuously
// until stopped.

module tff_toggle_sched #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               t,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] toggles_left
);

    localparam logic [CNT_W-1:0]   CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BURST_ZERO = '0;
    localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] hp;
    logic             finite;
    logic             toggle_now;

    // The counter has reached the last slot of the half period, so the next
    // edge issues a toggle; hp is never 0, so hp-1 cannot wrap.
    assign toggle_now = (counter == (hp - CNT_ONE));

    // Sequencer: every output is a register written only from here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= CNT_ZERO;
            hp           <= CNT_ONE;
            finite       <= 1'b0;
            t            <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            toggles_left <= BURST_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    t    <= 1'b0;
                    done <= 1'b0;
                    if (start && !stop) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        counter      <= CNT_ZERO;
                        hp           <= (half_period == CNT_ZERO) ? CNT_ONE : half_period;
                        toggles_left <= burst_len;
                        finite       <= (burst_len != BURST_ZERO);
                    end else begin
                        busy         <= 1'b0;
                        toggles_left <= BURST_ZERO;
                    end
                end

                RUN: begin
                    done <= 1'b0;
                    if (stop) begin
                        state        <= IDLE;
                        t            <= 1'b0;
                        busy         <= 1'b0;
                        counter      <= CNT_ZERO;
                        toggles_left <= BURST_ZERO;
                        finite       <= 1'b0;
                    end else if (finite && (toggles_left == BURST_ZERO)) begin
                        // The final toggle was issued last edge; announce completion.
                        state   <= DONE;
                        t       <= 1'b0;
                        done    <= 1'b1;
                        counter <= CNT_ZERO;
                    end else if (toggle_now) begin
                        counter <= CNT_ZERO;
                        t       <= 1'b1;
                        if (finite) begin
                            toggles_left <= toggles_left - BURST_ONE;
                        end
                    end else begin
                        counter <= counter + CNT_ONE;
                        t       <= 1'b0;
                    end
                end

                DONE: begin
                    state        <= IDLE;
                    t            <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    counter      <= CNT_ZERO;
                    toggles_left <= BURST_ZERO;
                    finite       <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    t            <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    counter      <= CNT_ZERO;
                    toggles_left <= BURST_ZERO;
                    finite       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tff_toggle_sched.sv
// tb_tff_toggle_sched
// Self-checking bench for tff_toggle_sched. The reference model describes a
// sequence only by how many edges have passed since the accepting edge,
// and derives every output from that count arithmetically.

module tb_tff_toggle_sched;

    localparam int CNT_W   = 8;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic [CNT_W-1:0]   half_period;
    logic [BURST_W-1:0] burst_len;
    logic               t;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] toggles_left;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a sequence is active, k edges old, with period mhp and
    // burst mn (mfin clear means continuous).
    bit m_active;
    int m_k;
    int m_hp;
    int m_n;
    bit m_fin;

    // Downstream T flop, toggled once for every cycle the DUT drives t high.
    bit tff_q;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    tff_toggle_sched #(
        .CNT_W  (CNT_W),
        .BURST_W(BURST_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .half_period (half_period),
        .burst_len   (burst_len),
        .t           (t),
        .busy        (busy),
        .done        (done),
        .toggles_left(toggles_left)
    );

    task automatic compareField(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs seen at that edge.
    task automatic modelEdge();
        int last_k;
        if (!reset) begin
            m_active = 1'b0;
            return;
        end
        if (!m_active) begin
            if (start && !stop) begin
                m_active = 1'b1;
                m_k      = 0;
                m_hp     = (half_period == 0) ? 1 : int'(half_period);
                m_n      = int'(burst_len);
                m_fin    = (burst_len != 0);
            end
        end else begin
            last_k = m_n * m_hp;
            if (m_fin && m_k == last_k + 1) begin
                m_active = 1'b0;
            end else if (stop) begin
                m_active = 1'b0;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic checkOutput();
        int exp_t;
        int exp_busy;
        int exp_done;
        int exp_tl;
        int last_k;
        exp_t    = 0;
        exp_busy = 0;
        exp_done = 0;
        exp_tl   = 0;
        if (m_active) begin
            last_k   = m_n * m_hp;
            exp_busy = 1;
            if (m_k > 0 && (m_k % m_hp) == 0 && (!m_fin || m_k <= last_k)) begin
                exp_t = 1;
            end
            if (m_fin && m_k == last_k + 1) begin
                exp_done = 1;
            end
            if (m_fin && m_k <= last_k) begin
                exp_tl = m_n - (m_k / m_hp);
            end
        end
        compareField("t", int'(t), exp_t);
        compareField("busy", int'(busy), exp_busy);
        compareField("done", int'(done), exp_done);
        compareField("toggles_left", int'(toggles_left), exp_tl);
        if (t) begin
            tff_q = ~tff_q;
        end
    endtask

    // Drive inputs, take one clock edge, then check outputs 1 unit later.
    task automatic applyStimulus(input bit s, input bit p, input int hpv, input int bl);
        start       = s;
        stop        = p;
        half_period = CNT_W'(hpv);
        burst_len   = BURST_W'(bl);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        int tmask;
        int dmask;
        int pulses;
        bit dseen;
        bit q0;

        m_active    = 1'b0;
        m_k         = 0;
        m_hp        = 1;
        m_n         = 0;
        m_fin       = 1'b0;
        tff_q       = 1'b0;
        reset       = 1'b1;
        start       = 1'b1;
        stop        = 1'b0;
        half_period = '0;
        burst_len   = '0;
        #1 reset = 1'b0;

        $display("[TB] reset held low with start high");
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 3, 4);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3, 4);
        compareField("idle_after_release_busy", int'(busy), 0);

        $display("[TB] finite burst hp=3 len=4");
        q0 = tff_q;
        tmask = 0;
        dmask = 0;
        applyStimulus(1, 0, 3, 4);
        for (int c = 1; c <= 15; c++) begin
            applyStimulus(0, 0, 3, 4);
            if (t) tmask |= (1 << c);
            if (done) dmask |= (1 << c);
            if (c == 3) compareField("tl_after_first", int'(toggles_left), 3);
            if (c == 12) compareField("tl_after_last", int'(toggles_left), 0);
            if (c == 14) compareField("busy_after_done", int'(busy), 0);
        end
        compareField("burst_t_positions", tmask, 32'h1248);
        compareField("burst_done_position", dmask, 32'h2000);
        compareField("tff_even_burst", int'(tff_q), int'(q0));

        $display("[TB] continuous hp=0 then stop");
        pulses = 0;
        dseen  = 1'b0;
        applyStimulus(1, 0, 0, 0);
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(0, 0, 0, 0);
            if (t) pulses++;
        end
        compareField("continuous_pulses", pulses, 10);
        applyStimulus(0, 1, 0, 0);
        compareField("stop_t", int'(t), 0);
        compareField("stop_busy", int'(busy), 0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 0, 0);
            if (done) dseen = 1'b1;
        end
        compareField("stop_no_done", int'(dseen), 0);

        $display("[TB] stop on first toggle edge");
        pulses = 0;
        applyStimulus(1, 0, 5, 2);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 0, 5, 2);
            if (t) pulses++;
        end
        applyStimulus(0, 1, 5, 2);
        if (t) pulses++;
        compareField("suppressed_pulses", pulses, 0);
        compareField("suppressed_busy", int'(busy), 0);
        compareField("suppressed_tl", int'(toggles_left), 0);

        $display("[TB] start mid-run ignored");
        pulses = 0;
        dseen  = 1'b0;
        applyStimulus(1, 0, 2, 3);
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) applyStimulus(1, 0, 7, 9);
            else        applyStimulus(0, 0, 7, 9);
            if (t) pulses++;
            if (done) dseen = 1'b1;
            if (c == 4) compareField("midrun_second_pulse", int'(t), 1);
        end
        compareField("midrun_pulses", pulses, 3);
        compareField("midrun_done", int'(dseen), 1);
        applyStimulus(1, 1, 2, 3);
        compareField("start_stop_idle", int'(busy), 0);

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1, 0, 4, 5);
        for (int c = 1; c <= 8; c++) applyStimulus(0, 0, 4, 5);
        compareField("before_async_t", int'(t), 1);
        #2 reset = 1'b0;
        #1;
        m_active = 1'b0;
        compareField("async_t", int'(t), 0);
        compareField("async_busy", int'(busy), 0);
        compareField("async_tl", int'(toggles_left), 0);
        #3 reset = 1'b1;
        pulses = 0;
        dseen  = 1'b0;
        applyStimulus(1, 0, 4, 1);
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(0, 0, 4, 1);
            if (t) pulses++;
            if (c == 4) compareField("after_reset_pulse_at_4", int'(t), 1);
            if (c == 5) compareField("after_reset_done_at_5", int'(done), 1);
            if (done) dseen = 1'b1;
        end
        compareField("after_reset_pulses", pulses, 1);
        compareField("after_reset_done", int'(dseen), 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 24) == 0,
                          int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
